// File: rtl/finger_thres_ctrl_if.sv
// Threshold-controller bundle: frame timing and finger flags in, converter thresholds and status out.
interface finger_thres_ctrl_if;
  logic        step;
  logic        cal_start;
  logic        frame_start;
  logic        pix_valid;
  logic        is_finger;
  logic [15:0] r_thres;
  logic [15:0] g_thres;
  logic [15:0] b_thres;
  logic        busy;
  logic        locked;
  logic        cal_fail;
  logic [15:0] debug_out;

  modport master (
    output step, cal_start, frame_start, pix_valid, is_finger,
    input  r_thres, g_thres, b_thres, busy, locked, cal_fail, debug_out
  );

  modport slave (
    input  step, cal_start, frame_start, pix_valid, is_finger,
    output r_thres, g_thres, b_thres, busy, locked, cal_fail, debug_out
  );
endinterface

// File: rtl/finger_thres_ctrl.sv
// Finger-detect threshold owner: manual R/B stepping plus a per-frame auto-calibration sweep.
module finger_thres_ctrl #(
  parameter int unsigned STEP       = 1024,
  parameter int unsigned TARGET_PIX = 2000,
  parameter int unsigned CNT_W      = 20,
  parameter logic [15:0] R_INIT     = 16'd35600,
  parameter logic [15:0] G_INIT     = 16'd51200,
  parameter logic [15:0] B_INIT     = 16'd35600
) (
  input  logic               clk,
  input  logic               rst_n,
  finger_thres_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, COUNT, EVAL} state_t;

  localparam logic [16:0]      STEP17  = 17'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [15:0]      r_rThres;
  logic [15:0]      r_gThres;
  logic [15:0]      r_bThres;
  logic [15:0]      r_rShadow;
  logic [15:0]      r_bShadow;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_result;
  logic             r_busy;
  logic             r_locked;
  logic             r_calFail;

  logic [16:0]      w_rSum;
  logic [16:0]      w_bSum;
  logic [15:0]      w_rNext;
  logic [15:0]      w_bNext;
  logic             w_rOverflow;
  logic             w_pixHit;
  logic             w_lockHit;

  // Sums are formed one bit wider so an overflow past 65535 can wrap to zero.
  always_comb begin
    w_rSum      = {1'b0, r_rThres} + STEP17;
    w_bSum      = {1'b0, r_bThres} + STEP17;
    w_rOverflow = (w_rSum > 17'h0FFFF);
    w_rNext     = w_rOverflow ? 16'd0 : w_rSum[15:0];
    w_bNext     = (w_bSum > 17'h0FFFF) ? 16'd0 : w_bSum[15:0];
    w_pixHit    = bus.pix_valid && bus.is_finger;
    w_lockHit   = (32'(r_result) >= 32'(TARGET_PIX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rThres  <= R_INIT;
      r_gThres  <= G_INIT;
      r_bThres  <= B_INIT;
      r_rShadow <= R_INIT;
      r_bShadow <= B_INIT;
      r_cnt     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_locked  <= 1'b0;
      r_calFail <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cal_start) begin
            r_rShadow <= r_rThres;
            r_bShadow <= r_bThres;
            r_rThres  <= 16'd0;
            r_bThres  <= 16'd0;
            r_busy    <= 1'b1;
            r_locked  <= 1'b0;
            r_calFail <= 1'b0;
            r_state   <= WAIT_FRAME;
          end else if (bus.step) begin
            r_rThres  <= w_rNext;
            r_bThres  <= w_bNext;
            r_locked  <= 1'b0;
            r_calFail <= 1'b0;
          end
        end
        // Pixels seen here belong to a frame measured with stale thresholds.
        WAIT_FRAME: begin
          if (bus.frame_start) begin
            r_cnt   <= '0;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (bus.frame_start) begin
            r_result <= r_cnt;
            r_state  <= EVAL;
          end else if (w_pixHit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          if (w_lockHit) begin
            r_locked <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (w_rOverflow) begin
            r_rThres  <= r_rShadow;
            r_bThres  <= r_bShadow;
            r_calFail <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_rThres <= w_rNext;
            r_bThres <= w_bNext;
            r_state  <= WAIT_FRAME;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.r_thres   = r_rThres;
  assign bus.g_thres   = r_gThres;
  assign bus.b_thres   = r_bThres;
  assign bus.busy      = r_busy;
  assign bus.locked    = r_locked;
  assign bus.cal_fail  = r_calFail;
  assign bus.debug_out = {r_rThres[15:8], r_bThres[15:8]};

endmodule

// File: tb/tb_finger_thres_ctrl.sv
// Scoreboard bench for finger_thres_ctrl: three instances cover default, saturating-counter and frame-edge cases.
module tb_finger_thres_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] sel;
  logic       step;
  logic       calStart;
  logic       frameStart;
  logic       pixValid;
  logic       isFinger;

  int checkCount;
  int errorCount;
  int expQ[$];

  finger_thres_ctrl_if bus1 ();
  finger_thres_ctrl_if bus2 ();
  finger_thres_ctrl_if bus3 ();

  // Only the selected instance sees activity; the others sit idle.
  assign bus1.step        = (sel == 2'd1) && step;
  assign bus1.cal_start   = (sel == 2'd1) && calStart;
  assign bus1.frame_start = (sel == 2'd1) && frameStart;
  assign bus1.pix_valid   = (sel == 2'd1) && pixValid;
  assign bus1.is_finger   = (sel == 2'd1) && isFinger;
  assign bus2.step        = (sel == 2'd2) && step;
  assign bus2.cal_start   = (sel == 2'd2) && calStart;
  assign bus2.frame_start = (sel == 2'd2) && frameStart;
  assign bus2.pix_valid   = (sel == 2'd2) && pixValid;
  assign bus2.is_finger   = (sel == 2'd2) && isFinger;
  assign bus3.step        = (sel == 2'd3) && step;
  assign bus3.cal_start   = (sel == 2'd3) && calStart;
  assign bus3.frame_start = (sel == 2'd3) && frameStart;
  assign bus3.pix_valid   = (sel == 2'd3) && pixValid;
  assign bus3.is_finger   = (sel == 2'd3) && isFinger;

  finger_thres_ctrl u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  finger_thres_ctrl #(.CNT_W(4), .TARGET_PIX(20)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  finger_thres_ctrl #(.TARGET_PIX(5)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] curR();
    case (sel)
      2'd2:    return bus2.r_thres;
      2'd3:    return bus3.r_thres;
      default: return bus1.r_thres;
    endcase
  endfunction

  function automatic logic [15:0] curB();
    case (sel)
      2'd2:    return bus2.b_thres;
      2'd3:    return bus3.b_thres;
      default: return bus1.b_thres;
    endcase
  endfunction

  function automatic logic curBusy();
    case (sel)
      2'd2:    return bus2.busy;
      2'd3:    return bus3.busy;
      default: return bus1.busy;
    endcase
  endfunction

  function automatic logic curLocked();
    case (sel)
      2'd2:    return bus2.locked;
      2'd3:    return bus3.locked;
      default: return bus1.locked;
    endcase
  endfunction

  function automatic logic curFail();
    case (sel)
      2'd2:    return bus2.cal_fail;
      2'd3:    return bus3.cal_fail;
      default: return bus1.cal_fail;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c);
    @(negedge clk);
    step     = s;
    calStart = c;
    @(negedge clk);
    step     = 1'b0;
    calStart = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays whole frames until calibration ends; trial values are popped at each measured frame start.
  task automatic runFrames(input int frameLen, input int mode, input int maxFrames, output int frames);
    int expVal;
    frames = 0;
    while ((curBusy() == 1'b1) && (frames < maxFrames)) begin
      for (int c = 0; c < frameLen; c++) begin
        @(negedge clk);
        if ((c == 0) && (frames % 2 == 0) && (expQ.size() > 0)) begin
          expVal = expQ.pop_front();
          checkOutput("trial_r", 32'(curR()), 32'(expVal));
        end
        frameStart = (c == 0);
        case (mode)
          1: begin
            pixValid = (c >= 1) && (c <= 2500);
            isFinger = pixValid && (curR() >= 16'd3072);
          end
          2: begin
            pixValid = (c >= 1) && (c <= 30);
            isFinger = pixValid;
          end
          3: begin
            pixValid = (c <= 4);
            isFinger = pixValid;
          end
          default: begin
            pixValid = (c >= 1);
            isFinger = 1'b0;
          end
        endcase
      end
      frames++;
    end
    @(negedge clk);
    frameStart = 1'b0;
    pixValid   = 1'b0;
    isFinger   = 1'b0;
  endtask

  initial begin
    int model;
    int expVal;
    int frames;
    checkCount = 0;
    errorCount = 0;
    sel        = 2'd1;
    rst_n      = 1'b0;
    step       = 1'b0;
    calStart   = 1'b0;
    frameStart = 1'b0;
    pixValid   = 1'b0;
    isFinger   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    checkOutput("rst_r", 32'(bus1.r_thres), 32'd35600);
    checkOutput("rst_g", 32'(bus1.g_thres), 32'd51200);
    checkOutput("rst_b", 32'(bus1.b_thres), 32'd35600);
    checkOutput("rst_busy", 32'(bus1.busy), 32'd0);
    checkOutput("rst_locked", 32'(bus1.locked), 32'd0);
    checkOutput("rst_fail", 32'(bus1.cal_fail), 32'd0);
    checkOutput("rst_debug", 32'(bus1.debug_out), 32'h8B8B);

    model = 35600;
    for (int i = 1; i <= 30; i++) begin
      model = (model + 1024 > 65535) ? 0 : model + 1024;
      expQ.push_back(model);
      applyStimulus(1'b1, 1'b0);
      expVal = expQ.pop_front();
      checkOutput("step_r", 32'(bus1.r_thres), 32'(expVal));
      checkOutput("step_b", 32'(bus1.b_thres), 32'(expVal));
    end
    checkOutput("step_g", 32'(bus1.g_thres), 32'd51200);

    for (int k = 0; k < 4; k++) expQ.push_back(k * 1024);
    applyStimulus(1'b0, 1'b1);
    checkOutput("cal_busy", 32'(bus1.busy), 32'd1);
    runFrames(2600, 1, 20, frames);
    checkOutput("lock_frames", 32'(frames), 32'd8);
    checkOutput("lock_r", 32'(bus1.r_thres), 32'd3072);
    checkOutput("lock_b", 32'(bus1.b_thres), 32'd3072);
    checkOutput("lock_locked", 32'(bus1.locked), 32'd1);
    checkOutput("lock_busy", 32'(bus1.busy), 32'd0);
    checkOutput("lock_fail", 32'(bus1.cal_fail), 32'd0);
    checkOutput("lock_queue", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("step_clr_locked", 32'(bus1.locked), 32'd0);
    checkOutput("step_after_lock", 32'(bus1.r_thres), 32'd4096);

    // Step and cal_start together: calibration must start from the unstepped value.
    doReset();
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_busy", 32'(bus1.busy), 32'd1);
    checkOutput("both_r", 32'(bus1.r_thres), 32'd0);
    checkOutput("both_b", 32'(bus1.b_thres), 32'd0);
    for (int k = 0; k < 64; k++) expQ.push_back(k * 1024);
    runFrames(20, 0, 140, frames);
    checkOutput("fail_frames", 32'(frames), 32'd128);
    checkOutput("fail_flag", 32'(bus1.cal_fail), 32'd1);
    checkOutput("fail_locked", 32'(bus1.locked), 32'd0);
    checkOutput("fail_busy", 32'(bus1.busy), 32'd0);
    checkOutput("fail_r", 32'(bus1.r_thres), 32'd35600);
    checkOutput("fail_b", 32'(bus1.b_thres), 32'd35600);
    checkOutput("fail_queue", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("step_clr_fail", 32'(bus1.cal_fail), 32'd0);
    checkOutput("step_after_fail", 32'(bus1.r_thres), 32'd36624);

    doReset();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("wait_ignore_r", 32'(bus1.r_thres), 32'd0);
    checkOutput("wait_ignore_busy", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("count_ignore_b", 32'(bus1.b_thres), 32'd0);
    doReset();
    checkOutput("abort_r", 32'(bus1.r_thres), 32'd35600);
    checkOutput("abort_g", 32'(bus1.g_thres), 32'd51200);
    checkOutput("abort_b", 32'(bus1.b_thres), 32'd35600);
    checkOutput("abort_busy", 32'(bus1.busy), 32'd0);
    checkOutput("abort_locked", 32'(bus1.locked), 32'd0);
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    checkOutput("idle_frame_busy", 32'(bus1.busy), 32'd0);
    expQ.push_back(36624);
    applyStimulus(1'b1, 1'b0);
    expVal = expQ.pop_front();
    checkOutput("abort_idle_step", 32'(bus1.r_thres), 32'(expVal));

    sel = 2'd2;
    doReset();
    applyStimulus(1'b0, 1'b1);
    runFrames(40, 2, 140, frames);
    checkOutput("sat_frames", 32'(frames), 32'd128);
    checkOutput("sat_fail", 32'(bus2.cal_fail), 32'd1);
    checkOutput("sat_locked", 32'(bus2.locked), 32'd0);
    checkOutput("sat_result", 32'(u_dut2.r_result), 32'd15);

    sel = 2'd3;
    doReset();
    applyStimulus(1'b0, 1'b1);
    runFrames(20, 3, 140, frames);
    checkOutput("edge_frames", 32'(frames), 32'd128);
    checkOutput("edge_fail", 32'(bus3.cal_fail), 32'd1);
    checkOutput("edge_locked", 32'(bus3.locked), 32'd0);
    checkOutput("edge_r", 32'(bus3.r_thres), 32'd35600);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
